// File: rtl/inst_fetch_pipe_pkg.sv
// Shared definitions for the instruction fetch pipe.
// Holds the 64-bit BPF instruction layout {opcode, jt, jf, k}, the decoded
// instruction payload struct, the bubble constant and the field unpack helper.
package inst_fetch_pipe_pkg;

    // Instruction word width and field bit positions
    localparam int unsigned INST_W    = 64;
    localparam int unsigned OPCODE_HI = 63;
    localparam int unsigned OPCODE_LO = 48;
    localparam int unsigned JT_HI     = 47;
    localparam int unsigned JT_LO     = 40;
    localparam int unsigned JF_HI     = 39;
    localparam int unsigned JF_LO     = 32;
    localparam int unsigned K_HI      = 31;
    localparam int unsigned K_LO      = 0;

    // Field widths derived from the positions above
    localparam int unsigned OPCODE_W  = OPCODE_HI - OPCODE_LO + 1;
    localparam int unsigned JMP_W     = JT_HI - JT_LO + 1;
    localparam int unsigned K_W       = K_HI - K_LO + 1;

    // Decoded instruction; field order matches the memory word layout
    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [JMP_W-1:0]    jt;
        logic [JMP_W-1:0]    jf;
        logic [K_W-1:0]      k;
    } inst_t;

    // A bubble carries all-zero fields
    localparam inst_t INST_BUBBLE = '0;

    // Split a raw memory word into its named fields
    function automatic inst_t unpack_inst(input logic [INST_W-1:0] raw);
        inst_t i;
        i.opcode = raw[OPCODE_HI:OPCODE_LO];
        i.jt     = raw[JT_HI:JT_LO];
        i.jf     = raw[JF_HI:JF_LO];
        i.k      = raw[K_HI:K_LO];
        return i;
    endfunction

endpackage

// File: rtl/inst_skid_buf.sv
// One-entry skid buffer holding an instruction word, its address tag and a
// valid bit.
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   load            capture data_in/addr_in and mark valid
//   unload          drop the entry (ignored when load is also set)
//   clear           drop the entry; dominates load and unload
//   data_in/addr_in incoming instruction word and its address tag
//   vld/data/addr   registered entry contents
module inst_skid_buf
    import inst_fetch_pipe_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              unload,
    input  logic              clear,
    input  logic [INST_W-1:0] data_in,
    input  logic [ADDR_W-1:0] addr_in,
    output logic              vld,
    output logic [INST_W-1:0] data,
    output logic [ADDR_W-1:0] addr
);

    // Entry register; a load together with an unload replaces the entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld  <= 1'b0;
            data <= '0;
            addr <= '0;
        end else if (clear) begin
            vld  <= 1'b0;
            data <= '0;
            addr <= '0;
        end else if (load) begin
            vld  <= 1'b1;
            data <= data_in;
            addr <= addr_in;
        end else if (unload) begin
            vld  <= 1'b0;
            data <= '0;
            addr <= '0;
        end
    end

endmodule

// File: rtl/inst_fetch_pipe.sv
// Instruction fetch and two-stage register pipe feeding the CPU datapath.
// Reads are issued at pc with one-cycle memory latency; returning words enter
// stage1 directly or via a one-entry skid buffer while the pipe is stalled.
// A flush kills stage1, the skid entry and any in-flight read.
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   pc, fetch_en             read address and read request for this cycle
//   inst_rd_en               memory read enable (mirrors fetch_en)
//   inst_rd_data             memory word returned one cycle after the read
//   stall, flush             hold both stages / kill the wrong path
//   vld/opcode/imm_stage1    stage1 contents
//   vld/opcode/imm_stage2    stage2 contents, jt/jf branch offsets
//   jmp_correction           pc - addr_stage2 - 1 while stage2 is valid
module inst_fetch_pipe
    import inst_fetch_pipe_pkg::*;
#(
    parameter int unsigned CODE_ADDR_WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CODE_ADDR_WIDTH-1:0] pc,
    input  logic                       fetch_en,
    output logic                       inst_rd_en,
    input  logic [INST_W-1:0]          inst_rd_data,
    input  logic                       stall,
    input  logic                       flush,
    output logic                       vld_stage1,
    output logic [OPCODE_W-1:0]        opcode_stage1,
    output logic [K_W-1:0]             imm_stage1,
    output logic                       vld_stage2,
    output logic [OPCODE_W-1:0]        opcode_stage2,
    output logic [K_W-1:0]             imm_stage2,
    output logic [JMP_W-1:0]           jt,
    output logic [JMP_W-1:0]           jf,
    output logic [CODE_ADDR_WIDTH-1:0] jmp_correction
);

    localparam int unsigned AW = CODE_ADDR_WIDTH;

    // Outstanding read: data on inst_rd_data this cycle belongs to pend_addr
    logic          pend_vld;
    logic [AW-1:0] pend_addr;

    // Stage registers
    logic          s1_vld;
    inst_t         s1_inst;
    logic [AW-1:0] s1_addr;
    logic          s2_vld;
    inst_t         s2_inst;
    logic [AW-1:0] s2_addr;

    // Next-state values for the stage registers
    logic          s1_vld_n;
    inst_t         s1_inst_n;
    logic [AW-1:0] s1_addr_n;
    logic          s2_vld_n;
    inst_t         s2_inst_n;
    logic [AW-1:0] s2_addr_n;

    // Skid buffer interface
    logic              skid_load;
    logic              skid_unload;
    logic              skid_clear;
    logic              skid_vld;
    logic [INST_W-1:0] skid_data;
    logic [AW-1:0]     skid_addr;
    inst_t             skid_inst;
    inst_t             arr_inst;

    assign inst_rd_en = fetch_en;
    assign arr_inst   = unpack_inst(inst_rd_data);
    assign skid_inst  = unpack_inst(skid_data);

    // Returning data parks in the skid while stalled, or when the skid is
    // occupied and must drain into stage1 first to keep program order.
    assign skid_clear  = flush;
    assign skid_load   = !flush && pend_vld && (stall || skid_vld);
    assign skid_unload = !flush && !stall && skid_vld;

    inst_skid_buf #(
        .ADDR_W (AW)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load    (skid_load),
        .unload  (skid_unload),
        .clear   (skid_clear),
        .data_in (inst_rd_data),
        .addr_in (pend_addr),
        .vld     (skid_vld),
        .data    (skid_data),
        .addr    (skid_addr)
    );

    // Read tracking; a read issued in a flush cycle is wrong-path and dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_vld  <= 1'b0;
            pend_addr <= '0;
        end else begin
            pend_vld <= fetch_en && !flush;
            if (fetch_en) begin
                pend_addr <= pc;
            end
        end
    end

    // Stage advance: flush bubbles both stages (the branch in stage2 retires),
    // stall holds, otherwise stage1 takes skid, then arriving data, then bubble.
    always_comb begin
        s1_vld_n  = s1_vld;
        s1_inst_n = s1_inst;
        s1_addr_n = s1_addr;
        s2_vld_n  = s2_vld;
        s2_inst_n = s2_inst;
        s2_addr_n = s2_addr;
        if (flush) begin
            s1_vld_n  = 1'b0;
            s1_inst_n = INST_BUBBLE;
            s1_addr_n = '0;
            s2_vld_n  = 1'b0;
            s2_inst_n = INST_BUBBLE;
            s2_addr_n = '0;
        end else if (!stall) begin
            s2_vld_n  = s1_vld;
            s2_inst_n = s1_inst;
            s2_addr_n = s1_addr;
            if (skid_vld) begin
                s1_vld_n  = 1'b1;
                s1_inst_n = skid_inst;
                s1_addr_n = skid_addr;
            end else if (pend_vld) begin
                s1_vld_n  = 1'b1;
                s1_inst_n = arr_inst;
                s1_addr_n = pend_addr;
            end else begin
                s1_vld_n  = 1'b0;
                s1_inst_n = INST_BUBBLE;
                s1_addr_n = '0;
            end
        end
    end

    // Stage registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld  <= 1'b0;
            s1_inst <= INST_BUBBLE;
            s1_addr <= '0;
            s2_vld  <= 1'b0;
            s2_inst <= INST_BUBBLE;
            s2_addr <= '0;
        end else begin
            s1_vld  <= s1_vld_n;
            s1_inst <= s1_inst_n;
            s1_addr <= s1_addr_n;
            s2_vld  <= s2_vld_n;
            s2_inst <= s2_inst_n;
            s2_addr <= s2_addr_n;
        end
    end

    assign vld_stage1    = s1_vld;
    assign opcode_stage1 = s1_inst.opcode;
    assign imm_stage1    = s1_inst.k;
    assign vld_stage2    = s2_vld;
    assign opcode_stage2 = s2_inst.opcode;
    assign imm_stage2    = s2_inst.k;
    assign jt            = s2_inst.jt;
    assign jf            = s2_inst.jf;

    // Datapath computes pc + offset - correction = addr_stage2 + 1 + offset
    assign jmp_correction = s2_vld ? (pc - s2_addr - AW'(1)) : '0;

`ifndef SYNTHESIS
    // The controller must not fetch while stalled with the skid occupied
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!(fetch_en && stall && !flush && skid_vld))
                else $error("inst_fetch_pipe: fetch_en during stall with skid full");
        end
    end
`endif

endmodule
